// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl
// Frame controller in front of a serial pattern detector. It holds a
// programmable pattern/mask and arms on a start command. It then shifts a
// fixed-length frame of serial bits through a WIDTH-bit window. It reports
// each match, a saturating match count and the index of the first match.
// All results are held until the next start.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset, clears all state
//   cfg_we       load cfg_pattern/cfg_mask (only in IDLE or DONE)
//   cfg_pattern  pattern; bit WIDTH-1 = newest bit, bit 0 = oldest
//   cfg_mask     1 = compare bit, 0 = don't care
//   start        begin a frame (only in IDLE or DONE)
//   frame_len    bits in the frame, sampled on an accepted start
//   sin          serial data bit
//   sin_valid    sin is valid this cycle
//   busy         high while scanning
//   done         high while holding the results of a finished frame
//   match_pulse  one cycle per detected match
//   match_count  matches in the current/last frame, saturating
//   first_pos    index of the bit completing the first match, all-ones if none
//   overflow     sticky: match_count saturated during this frame
module seq_detect_ctrl #(
    parameter int WIDTH = 3,
    parameter int CNTW  = 8,
    parameter int MCW   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_pattern,
    input  logic [WIDTH-1:0] cfg_mask,
    input  logic             start,
    input  logic [CNTW-1:0]  frame_len,
    input  logic             sin,
    input  logic             sin_valid,
    output logic             busy,
    output logic             done,
    output logic             match_pulse,
    output logic [MCW-1:0]   match_count,
    output logic [CNTW-1:0]  first_pos,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam int FW = $clog2(WIDTH + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] pattern;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] window;
    logic [FW-1:0]    fill;
    logic [CNTW-1:0]  index;
    logic [CNTW-1:0]  len;

    logic [WIDTH-1:0] win_next;
    logic [FW-1:0]    fill_next;
    logic             hit;
    logic             last_bit;

    // Saturating increment. The count sticks at all-ones.
    function automatic logic [MCW-1:0] sat_inc(input logic [MCW-1:0] v);
        return (&v) ? v : v + MCW'(1);
    endfunction

    // The decision for the bit being accepted this cycle uses the window as it
    // will be after the shift, so a match is reported on the same edge.
    always_comb begin
        win_next  = {sin, window[WIDTH-1:1]};
        fill_next = (fill == FILL_FULL) ? fill : fill + FW'(1);
        hit       = (fill_next == FILL_FULL) &&
                    ((win_next & mask) == (pattern & mask));
        last_bit  = (index == len - CNTW'(1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pattern     <= '1;
            mask        <= '1;
            window      <= '0;
            fill        <= '0;
            index       <= '0;
            len         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            match_pulse <= 1'b0;
            match_count <= '0;
            first_pos   <= '1;
            overflow    <= 1'b0;
        end else begin
            match_pulse <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    // Config and start can share an edge. The new pattern
                    // sits in its registers before the first bit is scanned.
                    if (cfg_we) begin
                        pattern <= cfg_pattern;
                        mask    <= cfg_mask;
                    end
                    if (start) begin
                        match_count <= '0;
                        overflow    <= 1'b0;
                        first_pos   <= '1;
                        window      <= '0;
                        fill        <= '0;
                        index       <= '0;
                        len         <= frame_len;
                        if (frame_len == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= SCAN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                end
                SCAN: begin
                    if (sin_valid) begin
                        window <= win_next;
                        fill   <= fill_next;
                        index  <= index + CNTW'(1);
                        if (hit) begin
                            match_pulse <= 1'b1;
                            match_count <= sat_inc(match_count);
                            if (&match_count) begin
                                overflow <= 1'b1;
                            end
                            if (&first_pos) begin
                                first_pos <= index;
                            end
                        end
                        if (last_bit) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
